// File: rtl/mem_read_arbiter_pkg.sv
// Shared definitions for the memory read arbiter: word size, VGA rebase offset,
// requester source enum and the in-flight read tag carried alongside each read.
package gc;

  localparam int unsigned WORD_SIZE = 16;
  localparam logic [WORD_SIZE-1:0] VGA_MEM_OFFSET = 16'h0400;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_VGA = 1'b1
  } arb_src_e;

  typedef struct packed {
    logic     valid;
    arb_src_e src;
  } arb_tag_t;

  // Character-buffer index to absolute word address; wraps modulo 2^WORD_SIZE.
  function automatic logic [WORD_SIZE-1:0] vga_rebase(input logic [WORD_SIZE-1:0] idx);
    return idx + VGA_MEM_OFFSET;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_tag_pipe.sv
// Depth-N shift register of read tags; synchronously cleared while rst_n is low.
module arb_tag_pipe
  import gc::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  arb_tag_t i_tag,
  output arb_tag_t o_tag
);

  arb_tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_read_arbiter.sv
// CPU/VGA arbiter for the single memory read port with tag-steered returns.
// Optional CPU starvation guard compiled in with `define ARB_STARVE_GUARD_EN.
module mem_read_arbiter
  import gc::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_CPU_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpuReq,
  input  logic [WORD_SIZE-1:0] cpuAdd,
  output logic                 cpuGnt,
  output logic                 cpuRvalid,
  output logic [WORD_SIZE-1:0] cpuRdata,
  input  logic                 vgaReq,
  input  logic [WORD_SIZE-1:0] vgaAdd,
  input  logic                 vgaUrgent,
  output logic                 vgaGnt,
  output logic                 vgaRvalid,
  output logic [WORD_SIZE-1:0] vgaRdata,
  output logic                 memReadEn,
  output logic [WORD_SIZE-1:0] memReadAdd,
  input  logic [WORD_SIZE-1:0] memDataRead
);

  if (READ_LATENCY < 1 || MAX_CPU_WAIT < 1) begin : g_param_check
    $error("mem_read_arbiter: READ_LATENCY and MAX_CPU_WAIT must be at least 1");
  end

  arb_src_e             r_last_gnt;
  logic                 r_mem_en;
  logic [WORD_SIZE-1:0] r_mem_add;
  arb_src_e             r_issue_src;
  logic                 w_cpu_gnt;
  logic                 w_vga_gnt;
  logic                 w_guard_hit;
  arb_tag_t             w_issue_tag;
  arb_tag_t             w_ret_tag;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CPU_WAIT);

  logic [CNT_W-1:0] r_cpu_wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_wait_cnt <= '0;
    end else if (!cpuReq || w_cpu_gnt) begin
      r_cpu_wait_cnt <= '0;
    end else if (r_cpu_wait_cnt != CNT_MAX) begin
      r_cpu_wait_cnt <= r_cpu_wait_cnt + 1'b1;
    end
  end

  assign w_guard_hit = cpuReq && (r_cpu_wait_cnt == CNT_MAX);
`else
  assign w_guard_hit = 1'b0;
`endif

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_vga_gnt = 1'b0;
    if (rst_n) begin
      if (w_guard_hit) begin
        w_cpu_gnt = 1'b1;
      end else if (vgaReq && vgaUrgent) begin
        w_vga_gnt = 1'b1;
      end else if (cpuReq && vgaReq) begin
        // Round-robin tie: whoever was not granted last goes now.
        if (r_last_gnt == SRC_VGA) begin
          w_cpu_gnt = 1'b1;
        end else begin
          w_vga_gnt = 1'b1;
        end
      end else if (cpuReq) begin
        w_cpu_gnt = 1'b1;
      end else if (vgaReq) begin
        w_vga_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_gnt  <= SRC_VGA;
      r_mem_en    <= 1'b0;
      r_mem_add   <= '0;
      r_issue_src <= SRC_CPU;
    end else begin
      r_mem_en <= w_cpu_gnt || w_vga_gnt;
      if (w_cpu_gnt) begin
        r_last_gnt  <= SRC_CPU;
        r_issue_src <= SRC_CPU;
        r_mem_add   <= cpuAdd;
      end else if (w_vga_gnt) begin
        r_last_gnt  <= SRC_VGA;
        r_issue_src <= SRC_VGA;
        r_mem_add   <= vga_rebase(vgaAdd);
      end
    end
  end

  // The issue register is the first tag stage; the pipe then spans the memory latency.
  assign w_issue_tag = '{valid: r_mem_en, src: r_issue_src};

  arb_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_issue_tag),
    .o_tag (w_ret_tag)
  );

  assign cpuGnt     = w_cpu_gnt;
  assign vgaGnt     = w_vga_gnt;
  assign memReadEn  = r_mem_en;
  assign memReadAdd = r_mem_add;
  assign cpuRvalid  = rst_n && w_ret_tag.valid && (w_ret_tag.src == SRC_CPU);
  assign vgaRvalid  = rst_n && w_ret_tag.valid && (w_ret_tag.src == SRC_VGA);
  assign cpuRdata   = memDataRead;
  assign vgaRdata   = memDataRead;

endmodule
